// File: rtl/stitch_pkg.sv
// Shared constants and output decode for the stereo stitch sequencer.
// State codes are plain localparams so legacy tooling can read them.
package stitch_pkg;

  localparam int FRAME_PIXELS_DEF = 64;
  localparam int ADDR_W_DEF       = 6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CAP_L  = 3'd1;
  localparam logic [2:0] ST_CAP_R  = 3'd2;
  localparam logic [2:0] ST_PROC_L = 3'd3;
  localparam logic [2:0] ST_PROC_R = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic BANK_L   = 1'b0;
  localparam logic BANK_R   = 1'b1;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef struct packed {
    logic cam_l_enable;
    logic cam_r_enable;
    logic rwm_enable;
    logic rw;
    logic bank_sel;
    logic gs_enable;
    logic busy;
    logic frame_done;
  } stitch_ctrl_t;

  // Moore decode: every control output is a pure function of the state code.
  function automatic stitch_ctrl_t decode_ctrl(input logic [2:0] st);
    stitch_ctrl_t c;
    c = '0;
    case (st)
      ST_CAP_L: begin
        c.cam_l_enable = 1'b1;
        c.rwm_enable   = 1'b1;
        c.rw           = RW_WRITE;
        c.bank_sel     = BANK_L;
      end
      ST_CAP_R: begin
        c.cam_r_enable = 1'b1;
        c.rwm_enable   = 1'b1;
        c.rw           = RW_WRITE;
        c.bank_sel     = BANK_R;
      end
      ST_PROC_L: begin
        c.gs_enable  = 1'b1;
        c.rwm_enable = 1'b1;
        c.rw         = RW_READ;
        c.bank_sel   = BANK_L;
      end
      ST_PROC_R: begin
        c.gs_enable  = 1'b1;
        c.rwm_enable = 1'b1;
        c.rw         = RW_READ;
        c.bank_sel   = BANK_R;
      end
      ST_DONE: c.frame_done = 1'b1;
      default: ;
    endcase
    c.busy = (st != ST_IDLE);
    return c;
  endfunction

endpackage

// File: rtl/stitch_addr_counter.sv
// Frame pixel address counter: clears, steps on enable, and wraps to zero
// after the last pixel so the next phase always starts at address 0.
module stitch_addr_counter
  import stitch_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clear) begin
      addr_d = '0;
    end else if (enable) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = (addr_q == LAST_ADDR);

endmodule

// File: rtl/stitch_sequencer.sv
// Sequences one stereo stitch: capture left, capture right, grayscale left,
// grayscale right, then a one-cycle completion pulse.
module stitch_sequencer
  import stitch_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cam_l_valid,
  input  logic              cam_r_valid,
  input  logic              gs_pause,
  output logic              cam_l_enable,
  output logic              cam_r_enable,
  output logic              rwm_enable,
  output logic              rw,
  output logic              bank_sel,
  output logic [ADDR_W-1:0] addr,
  output logic              gs_enable,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_count
);

  logic [2:0]   state_q, state_d;
  logic [7:0]   frame_count_q, frame_count_d;
  logic         beat;
  logic         addr_last;
  logic         addr_clear;
  logic         abort_act;
  logic         phase_end;
  stitch_ctrl_t ctrl;

  // A "beat" is whatever advances the address in the current phase.
  always_comb begin
    beat = 1'b0;
    case (state_q)
      ST_CAP_L:             beat = cam_l_valid;
      ST_CAP_R:             beat = cam_r_valid;
      ST_PROC_L, ST_PROC_R: beat = !gs_pause;
      default:              beat = 1'b0;
    endcase
  end

  assign abort_act  = abort && (state_q != ST_IDLE);
  assign phase_end  = beat && addr_last;
  assign addr_clear = abort_act || (state_q == ST_IDLE) || (state_q == ST_DONE);

  stitch_addr_counter #(
    .FRAME_PIXELS (FRAME_PIXELS),
    .ADDR_W       (ADDR_W)
  ) u_addr (
    .clk    (clk),
    .rst    (rst),
    .clear  (addr_clear),
    .enable (beat),
    .addr   (addr),
    .last   (addr_last)
  );

  always_comb begin
    state_d       = state_q;
    frame_count_d = frame_count_q;
    if (abort_act) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start && !abort) state_d = ST_CAP_L;
        ST_CAP_L:  if (phase_end) state_d = ST_CAP_R;
        ST_CAP_R:  if (phase_end) state_d = ST_PROC_L;
        ST_PROC_L: if (phase_end) state_d = ST_PROC_R;
        ST_PROC_R: begin
          // Count on entry to DONE so frame_count is current while frame_done is high.
          if (phase_end) begin
            state_d       = ST_DONE;
            frame_count_d = frame_count_q + 8'd1;
          end
        end
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign ctrl         = decode_ctrl(state_q);
  assign cam_l_enable = ctrl.cam_l_enable;
  assign cam_r_enable = ctrl.cam_r_enable;
  assign rwm_enable   = ctrl.rwm_enable;
  assign rw           = ctrl.rw;
  assign bank_sel     = ctrl.bank_sel;
  assign gs_enable    = ctrl.gs_enable;
  assign busy         = ctrl.busy;
  assign frame_done   = ctrl.frame_done;
  assign frame_count  = frame_count_q;

endmodule
